// File: rtl/mips_debug_ctrl.sv
// Debug sequencer for the 5-stage MIPS core.
// Decodes byte commands from a UART/SPI byte link and either loads instruction
// memory, runs, single-steps, or freezes the pipeline. A frozen pipeline is
// dumped back over the link as PC, register file, then a data memory window.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_rx_data/i_rx_valid/o_rx_ready   command byte link (valid/ready)
//   o_tx_data/o_tx_valid/i_tx_ready   response byte link (valid/ready)
//   o_imem_we/o_imem_addr/o_imem_data instruction memory write port
//   o_pipe_rst_n                 pipeline reset, held low while loading
//   o_debug_enb, o_step          freeze control and one-cycle advance pulse
//   i_halt, i_pc                 HALT retired in WB, current fetch PC
//   o_reg_addr/i_reg_data        register file debug read (1-cycle latency)
//   o_mem_addr/i_mem_data        data memory debug read (1-cycle latency)
//   o_busy                       high whenever the sequencer is not idle
module mips_debug_ctrl #(
  parameter int unsigned NB_BITS    = 32,
  parameter int unsigned NB_REG     = 5,
  parameter int unsigned NB_IADDR   = 10,
  parameter int unsigned NB_DADDR   = 10,
  parameter int unsigned N_MEM_DUMP = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_rx_ready,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_imem_we,
  output logic [NB_IADDR-1:0] o_imem_addr,
  output logic [NB_BITS-1:0]  o_imem_data,
  output logic                o_pipe_rst_n,
  output logic                o_debug_enb,
  output logic                o_step,
  input  logic                i_halt,
  input  logic [NB_BITS-1:0]  i_pc,
  output logic [NB_REG-1:0]   o_reg_addr,
  input  logic [NB_BITS-1:0]  i_reg_data,
  output logic [NB_DADDR-1:0] o_mem_addr,
  input  logic [NB_BITS-1:0]  i_mem_data,
  output logic                o_busy
);

  localparam int unsigned N_BYTES   = NB_BITS / 8;
  localparam int unsigned NB_BCNT   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int unsigned N_REGS    = 2 ** NB_REG;
  localparam int unsigned N_IDX_MAX = (N_REGS > N_MEM_DUMP) ? N_REGS : N_MEM_DUMP;
  localparam int unsigned NB_IDX    = (N_IDX_MAX > 1) ? $clog2(N_IDX_MAX) : 1;
  localparam int unsigned NB_WCNT   = 9;

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_STEP  = 8'h03;
  localparam logic [7:0] CMD_DUMP  = 8'h04;
  localparam logic [7:0] CMD_BREAK = 8'h05;
  localparam logic [7:0] RSP_ACK   = 8'hA5;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_BYTES,
    ST_LOAD_WR,
    ST_RUN,
    ST_STEP,
    ST_DUMP_PC,
    ST_DUMP_WAIT,
    ST_DUMP_CAP,
    ST_DUMP_SEND,
    ST_REPLY
  } state_t;

  // Which section of the dump the current word belongs to.
  typedef enum logic [1:0] {
    PH_PC,
    PH_REG,
    PH_MEM
  } phase_t;

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [NB_IDX-1:0]     idx_q, idx_d;
  logic [NB_BCNT-1:0]    bcnt_q, bcnt_d;
  logic [NB_WCNT-1:0]    words_left_q, words_left_d;
  logic [NB_BITS-1:0]    word_q, word_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [NB_IADDR-1:0]   imem_addr_q, imem_addr_d;
  logic [NB_BITS-1:0]    imem_data_q, imem_data_d;
  logic                  pipe_rst_n_q, pipe_rst_n_d;
  logic                  debug_enb_q, debug_enb_d;
  logic                  step_q, step_d;
  logic [NB_REG-1:0]     reg_addr_q, reg_addr_d;
  logic [NB_DADDR-1:0]   mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;

  logic                  rx_fire;
  logic                  tx_fire;
  logic [NB_BITS-1:0]    shift_in;
  logic [NB_BITS-1:0]    cap_word;
  logic [NB_IDX-1:0]     idx_inc;
  logic                  last_byte;

  assign rx_fire   = rx_ready_q & i_rx_valid;
  assign tx_fire   = tx_valid_q & i_tx_ready;
  assign shift_in  = {word_q[NB_BITS-9:0], i_rx_data};
  assign cap_word  = (phase_q == PH_REG) ? i_reg_data : i_mem_data;
  assign idx_inc   = idx_q + 1'b1;
  assign last_byte = (bcnt_q == NB_BCNT'(N_BYTES - 1));

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_PC;
      idx_q        <= '0;
      bcnt_q       <= '0;
      words_left_q <= '0;
      word_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      pipe_rst_n_q <= 1'b1;
      debug_enb_q  <= 1'b1;
      step_q       <= 1'b0;
      reg_addr_q   <= '0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      bcnt_q       <= bcnt_d;
      words_left_q <= words_left_d;
      word_q       <= word_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      pipe_rst_n_q <= pipe_rst_n_d;
      debug_enb_q  <= debug_enb_d;
      step_q       <= step_d;
      reg_addr_q   <= reg_addr_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    bcnt_d       = bcnt_q;
    words_left_d = words_left_q;
    word_d       = word_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    pipe_rst_n_d = pipe_rst_n_q;
    debug_enb_d  = debug_enb_q;
    step_d       = 1'b0;
    reg_addr_d   = reg_addr_q;
    mem_addr_d   = mem_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d      = ST_LOAD_CNT;
              pipe_rst_n_d = 1'b0;
              imem_addr_d  = '0;
            end
            CMD_RUN: begin
              state_d     = ST_RUN;
              debug_enb_d = 1'b0;
            end
            CMD_STEP: begin
              state_d = ST_STEP;
              step_d  = 1'b1;
            end
            CMD_DUMP: state_d = ST_DUMP_PC;
            default: begin
              state_d    = ST_REPLY;
              tx_data_d  = RSP_ERR;
              tx_valid_d = 1'b1;
            end
          endcase
        end
      end

      // A count byte of zero encodes a full 256-word load.
      ST_LOAD_CNT: begin
        if (rx_fire) begin
          words_left_d = (i_rx_data == 8'h00) ? NB_WCNT'(256) : {1'b0, i_rx_data};
          bcnt_d       = '0;
          state_d      = ST_LOAD_BYTES;
        end
      end

      ST_LOAD_BYTES: begin
        if (rx_fire) begin
          word_d = shift_in;
          if (last_byte) begin
            bcnt_d      = '0;
            imem_we_d   = 1'b1;
            imem_data_d = shift_in;
            state_d     = ST_LOAD_WR;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end

      // The write strobe is on the outputs this cycle; advance afterwards.
      ST_LOAD_WR: begin
        imem_addr_d  = imem_addr_q + 1'b1;
        words_left_d = words_left_q - 1'b1;
        if (words_left_q == NB_WCNT'(1)) begin
          state_d      = ST_REPLY;
          tx_data_d    = RSP_ACK;
          tx_valid_d   = 1'b1;
          pipe_rst_n_d = 1'b1;
        end else begin
          state_d = ST_LOAD_BYTES;
        end
      end

      // Halt and break byte share one exit, so coincident events dump once.
      ST_RUN: begin
        if (i_halt || (rx_fire && (i_rx_data == CMD_BREAK))) begin
          debug_enb_d = 1'b1;
          state_d     = ST_DUMP_PC;
        end
      end

      ST_STEP: state_d = ST_DUMP_PC;

      ST_DUMP_PC: begin
        phase_d    = PH_PC;
        word_d     = {i_pc[NB_BITS-9:0], 8'h00};
        tx_data_d  = i_pc[NB_BITS-1 -: 8];
        tx_valid_d = 1'b1;
        bcnt_d     = '0;
        state_d    = ST_DUMP_SEND;
      end

      // Read address is on the bus this cycle; data arrives next cycle.
      ST_DUMP_WAIT: state_d = ST_DUMP_CAP;

      ST_DUMP_CAP: begin
        word_d     = {cap_word[NB_BITS-9:0], 8'h00};
        tx_data_d  = cap_word[NB_BITS-1 -: 8];
        tx_valid_d = 1'b1;
        bcnt_d     = '0;
        state_d    = ST_DUMP_SEND;
      end

      // Bytes leave MSB first; the next read is issued only once the
      // current word's final byte has been accepted.
      ST_DUMP_SEND: begin
        if (tx_fire) begin
          if (last_byte) begin
            tx_valid_d = 1'b0;
            case (phase_q)
              PH_PC: begin
                phase_d    = PH_REG;
                idx_d      = '0;
                reg_addr_d = '0;
                state_d    = ST_DUMP_WAIT;
              end
              PH_REG: begin
                if (idx_q == NB_IDX'(N_REGS - 1)) begin
                  phase_d    = PH_MEM;
                  idx_d      = '0;
                  mem_addr_d = '0;
                end else begin
                  idx_d      = idx_inc;
                  reg_addr_d = NB_REG'(idx_inc);
                end
                state_d = ST_DUMP_WAIT;
              end
              default: begin
                if (idx_q == NB_IDX'(N_MEM_DUMP - 1)) begin
                  state_d = ST_IDLE;
                end else begin
                  idx_d      = idx_inc;
                  mem_addr_d = NB_DADDR'(idx_inc);
                  state_d    = ST_DUMP_WAIT;
                end
              end
            endcase
          end else begin
            tx_data_d = word_q[NB_BITS-1 -: 8];
            word_d    = {word_q[NB_BITS-9:0], 8'h00};
            bcnt_d    = bcnt_q + 1'b1;
          end
        end
      end

      ST_REPLY: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD_CNT) ||
                 (state_d == ST_LOAD_BYTES) || (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
  end

  assign o_rx_ready   = rx_ready_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_imem_we    = imem_we_q;
  assign o_imem_addr  = imem_addr_q;
  assign o_imem_data  = imem_data_q;
  assign o_pipe_rst_n = pipe_rst_n_q;
  assign o_debug_enb  = debug_enb_q;
  assign o_step       = step_q;
  assign o_reg_addr   = reg_addr_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Scoreboard bench for mips_debug_ctrl: stimulus pushes expected tx bytes and
// imem writes into queues; a negedge monitor pops and compares them.
module tb_mips_debug_ctrl;

  localparam int unsigned NB_BITS    = 32;
  localparam int unsigned NB_REG     = 5;
  localparam int unsigned NB_IADDR   = 10;
  localparam int unsigned NB_DADDR   = 10;
  localparam int unsigned N_MEM_DUMP = 16;
  localparam int          DUMP_BYTES = 4 + 128 + 4 * N_MEM_DUMP;

  logic                i_clk;
  logic                i_rst;
  logic [7:0]          i_rx_data;
  logic                i_rx_valid;
  logic                o_rx_ready;
  logic [7:0]          o_tx_data;
  logic                o_tx_valid;
  logic                i_tx_ready;
  logic                o_imem_we;
  logic [NB_IADDR-1:0] o_imem_addr;
  logic [NB_BITS-1:0]  o_imem_data;
  logic                o_pipe_rst_n;
  logic                o_debug_enb;
  logic                o_step;
  logic                i_halt;
  logic [NB_BITS-1:0]  i_pc;
  logic [NB_REG-1:0]   o_reg_addr;
  logic [NB_BITS-1:0]  i_reg_data;
  logic [NB_DADDR-1:0] o_mem_addr;
  logic [NB_BITS-1:0]  i_mem_data;
  logic                o_busy;

  mips_debug_ctrl #(
    .NB_BITS(NB_BITS), .NB_REG(NB_REG), .NB_IADDR(NB_IADDR),
    .NB_DADDR(NB_DADDR), .N_MEM_DUMP(N_MEM_DUMP)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_pipe_rst_n(o_pipe_rst_n), .o_debug_enb(o_debug_enb), .o_step(o_step),
    .i_halt(i_halt), .i_pc(i_pc),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference state of the core seen by the debugger.
  logic [31:0] regs [32];
  logic [31:0] dmem [16];

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic [7:0] tx_q [$];
  wr_t        wr_q [$];

  int checks = 0;
  int passed = 0;
  int step_cnt = 0;
  int we_cnt = 0;
  int tx_cnt = 0;
  int viol = 0;
  bit bp_mode = 1'b0;
  bit prev_we = 1'b0;

  // Core-side read ports with one cycle of latency.
  always @(posedge i_clk) begin
    i_reg_data <= regs[o_reg_addr];
    i_mem_data <= (o_mem_addr < 10'd16) ? dmem[o_mem_addr[3:0]] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: decides tx_ready for the coming edge and scores any transfer.
  always @(negedge i_clk) begin
    bit rdy;
    rdy = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    i_tx_ready = rdy;
    if (o_tx_valid && rdy) begin
      tx_cnt++;
      if (tx_q.size() == 0) begin
        checks++;
        $display("FAIL tx_unexpected: got %h expected no byte", o_tx_data);
      end else begin
        chk("tx_byte", {24'h0, o_tx_data}, {24'h0, tx_q.pop_front()});
      end
    end
    if (o_imem_we) begin
      wr_t w;
      we_cnt++;
      if (prev_we || o_pipe_rst_n) viol++;
      if (wr_q.size() == 0) begin
        checks++;
        $display("FAIL imem_unexpected: got addr %h data %h expected no write", o_imem_addr, o_imem_data);
      end else begin
        w = wr_q.pop_front();
        chk("imem_addr", {22'h0, o_imem_addr}, {22'h0, w.a});
        chk("imem_data", o_imem_data, w.d);
      end
    end
    prev_we = o_imem_we;
    if (o_step) begin
      step_cnt++;
      if (!o_debug_enb || o_imem_we) viol++;
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) tx_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] pc);
    push_word(pc);
    for (int r = 0; r < 32; r++) push_word(regs[r]);
    for (int m = 0; m < 16; m++) push_word(dmem[m]);
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.a = 10'(a);
    w.d = d;
    wr_q.push_back(w);
  endtask

  // Called and returns on a negedge.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    for (int k = 0; k < 2000 && !done; k++) begin
      if (o_rx_ready) done = 1'b1;
      @(negedge i_clk);
    end
    i_rx_valid = 1'b0;
    chk("rx_accept", {31'h0, done}, 32'h1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge i_clk);
      if (!o_busy && tx_q.size() == 0 && wr_q.size() == 0) ok = 1'b1;
    end
    chk("idle_reached", {31'h0, ok}, 32'h1);
  endtask

  task automatic load_words(input int n, input bit random_data);
    logic [31:0] d;
    send_byte(8'h01);
    send_byte(8'(n));
    chk("pipe_rst_n_low", {31'h0, o_pipe_rst_n}, 32'h0);
    for (int w = 0; w < ((n == 0) ? 256 : n); w++) begin
      d = random_data ? $urandom : 32'h0;
      push_wr(w, d);
      for (int b = 3; b >= 0; b--) send_byte(d[b*8 +: 8]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_debug_enb"}, {31'h0, o_debug_enb}, 32'h1);
    chk({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
    chk({tag, "_tx_valid"}, {31'h0, o_tx_valid}, 32'h0);
    chk({tag, "_imem_we"}, {31'h0, o_imem_we}, 32'h0);
    chk({tag, "_pipe_rst_n"}, {31'h0, o_pipe_rst_n}, 32'h1);
    chk({tag, "_step"}, {31'h0, o_step}, 32'h0);
    chk({tag, "_rx_ready"}, {31'h0, o_rx_ready}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_we;
    int s0;
    int t0;
    int w0;
    int run_bad;
    int n;
    logic [7:0] bad_cmds [5];
    logic [31:0] d;

    i_rst = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0; i_halt = 1'b0;
    i_pc = 32'h0; i_tx_ready = 1'b1;
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    regs[1] = 32'h5;
    for (int m = 0; m < 16; m++) dmem[m] = $urandom;

    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    check_reset_outputs("reset");
    @(negedge i_clk);
    chk("idle_rx_ready", {31'h0, o_rx_ready}, 32'h1);

    // Directed load of two words, then random loads incl. count 0 = 256.
    push_wr(0, 32'h20010005);
    push_wr(1, 32'h00000000);
    tx_q.push_back(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("pipe_rst_n_low", {31'h0, o_pipe_rst_n}, 32'h0);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_idle();
    chk("pipe_rst_n_release", {31'h0, o_pipe_rst_n}, 32'h1);
    chk("load_we_count", we_cnt, 2);
    exp_we = 2;
    for (int t = 0; t < 2; t++) begin
      n = $urandom_range(1, 6);
      tx_q.push_back(8'hA5);
      load_words(n, 1'b1);
      wait_idle();
      exp_we += n;
    end
    tx_q.push_back(8'hA5);
    load_words(0, 1'b1);
    wait_idle();
    exp_we += 256;
    chk("load_we_total", we_cnt, exp_we);

    // Single step with pc=8 and reg[1]=5.
    i_pc = 32'h00000008;
    push_dump(i_pc);
    s0 = step_cnt; t0 = tx_cnt;
    send_byte(8'h03);
    wait_idle();
    chk("step_pulses", step_cnt - s0, 1);
    chk("step_dump_len", tx_cnt - t0, DUMP_BYTES);

    // Run with discarded bytes, then halt after 50 cycles.
    s0 = step_cnt; t0 = tx_cnt; run_bad = 0;
    send_byte(8'h02);
    chk("run_debug_enb", {31'h0, o_debug_enb}, 32'h0);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(6, 255)));
    for (int k = 0; k < 50; k++) begin
      @(negedge i_clk);
      if (o_debug_enb || o_busy == 1'b0) run_bad++;
    end
    chk("run_frozen_cycles", run_bad, 0);
    i_pc = $urandom;
    push_dump(i_pc);
    i_halt = 1'b1;
    @(negedge i_clk);
    i_halt = 1'b0;
    chk("halt_debug_enb", {31'h0, o_debug_enb}, 32'h1);
    wait_idle();
    chk("halt_dump_len", tx_cnt - t0, DUMP_BYTES);
    chk("run_no_step", step_cnt - s0, 0);

    // Break byte alone, then break byte coincident with halt: one dump each.
    for (int t = 0; t < 2; t++) begin
      t0 = tx_cnt;
      i_pc = $urandom;
      send_byte(8'h02);
      repeat (5) @(negedge i_clk);
      push_dump(i_pc);
      i_halt = (t == 1);
      send_byte(8'h05);
      i_halt = 1'b0;
      wait_idle();
      chk("break_dump_len", tx_cnt - t0, DUMP_BYTES);
    end

    // Dump under random 30% tx_ready; stream must match the model exactly.
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    for (int m = 0; m < 16; m++) dmem[m] = $urandom;
    i_pc = $urandom;
    t0 = tx_cnt;
    push_dump(i_pc);
    bp_mode = 1'b1;
    send_byte(8'h04);
    wait_idle();
    bp_mode = 1'b0;
    chk("bp_dump_len", tx_cnt - t0, DUMP_BYTES);

    // Unknown commands answer 0xEE and leave the pipeline alone.
    bad_cmds[0] = 8'h7F; bad_cmds[1] = 8'h00; bad_cmds[2] = 8'h05;
    bad_cmds[3] = 8'hFF; bad_cmds[4] = 8'($urandom_range(6, 254));
    s0 = step_cnt; w0 = we_cnt;
    for (int k = 0; k < 5; k++) begin
      tx_q.push_back(8'hEE);
      send_byte(bad_cmds[k]);
      wait_idle();
      chk("err_pipe_rst_n", {31'h0, o_pipe_rst_n}, 32'h1);
      chk("err_debug_enb", {31'h0, o_debug_enb}, 32'h1);
    end
    chk("err_no_step", step_cnt - s0, 0);
    chk("err_no_write", we_cnt - w0, 0);

    // Reset in the middle of a word: nothing written, clean restart after.
    w0 = we_cnt;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("midload_reset");
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("midload_no_write", we_cnt - w0, 0);
    d = $urandom;
    push_wr(0, d);
    tx_q.push_back(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    for (int b = 3; b >= 0; b--) send_byte(d[b*8 +: 8]);
    wait_idle();
    chk("restart_we", we_cnt - w0, 1);

    chk("invariants", viol, 0);
    chk("tx_queue_empty", tx_q.size(), 0);
    chk("wr_queue_empty", wr_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
